// File: rtl/sc_scbc_sofg_if.sv
// SOF token transmit bus: request/grant plus byte-wise valid/ready.
// master = SOF generator, slave = ULPI transmit arbiter.
interface sc_scbc_sofg_if;
  logic       SOF_TXREQ;
  logic       SOF_TXGNT;
  logic [7:0] SOF_TXDAT;
  logic       SOF_TXVLD;
  logic       SOF_TXRDY;
  logic       SOF_TXLAST;

  modport master (
    output SOF_TXREQ,
    output SOF_TXDAT,
    output SOF_TXVLD,
    output SOF_TXLAST,
    input  SOF_TXGNT,
    input  SOF_TXRDY
  );

  modport slave (
    input  SOF_TXREQ,
    input  SOF_TXDAT,
    input  SOF_TXVLD,
    input  SOF_TXLAST,
    output SOF_TXGNT,
    output SOF_TXRDY
  );
endinterface

// File: rtl/sc_scbc_sofg.sv
// USB SOF token generator: PID, 11-bit frame number, CRC5, byte-wise.
// Macro SC_SCBC_SOFG_MISSCNT_EN enables the dropped-SOF counter.
module sc_scbc_sofg #(
  parameter logic [7:0] SOF_PID     = 8'hA5,
  parameter int         GNT_TIMEOUT = 64
) (
  input  logic                  ULPICLK,
  input  logic                  ULPIRSTB,
  input  logic                  UPS_OPERATIONAL,
  input  logic                  FT_1MS,
  input  logic [15:0]           FT_FMNUMBER,
  sc_scbc_sofg_if.master        tx,
  output logic                  SOF_BUSY,
  output logic [7:0]            SOF_MISSED
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    PID,
    FNL,
    FNH
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(GNT_TIMEOUT - 1);

  state_t      st;
  state_t      st_nxt;
  logic [10:0] fn;
  logic [4:0]  crc;
  logic        fb;
  logic [7:0]  tmo;
  logic        start;
  logic        tick_busy;
  logic        drop;
  logic        acc;
  logic        req;
  logic        vld;
  logic        last;
  logic [7:0]  dat;

  assign start     = FT_1MS && UPS_OPERATIONAL && (st == IDLE);
  assign tick_busy = FT_1MS && UPS_OPERATIONAL && (st != IDLE);
  assign acc       = vld && tx.SOF_TXRDY;

  // State register
  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB) st <= IDLE;
    else           st <= st_nxt;
  end

  // Frame number latched on an accepted tick
  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB)  fn <= '0;
    else if (start) fn <= FT_FMNUMBER[10:0];
  end

  // Grant wait counter, runs only while requesting
  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB)      tmo <= '0;
    else if (st != REQ) tmo <= '0;
    else                tmo <= tmo + 8'd1;
  end

  // CRC5 over the latched frame number, LSB first, unrolled
  always_comb begin
    crc = 5'h1F;
    fb  = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb  = crc[4] ^ fn[i];
      crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
  end

  // Next state and token byte outputs
  always_comb begin
    st_nxt = st;
    req    = 1'b0;
    vld    = 1'b0;
    last   = 1'b0;
    dat    = 8'h00;
    drop   = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) st_nxt = REQ;
      end
      REQ: begin
        req = 1'b1;
        if (!UPS_OPERATIONAL) begin
          st_nxt = IDLE;
          drop   = 1'b1;
        end else if (tx.SOF_TXGNT) begin
          st_nxt = PID;
        end else if (tmo == TMO_LAST) begin
          st_nxt = IDLE;
          drop   = 1'b1;
        end
      end
      PID: begin
        req = 1'b1;
        vld = 1'b1;
        dat = SOF_PID;
        if (acc) st_nxt = FNL;
      end
      FNL: begin
        req = 1'b1;
        vld = 1'b1;
        dat = fn[7:0];
        if (acc) st_nxt = FNH;
      end
      FNH: begin
        req  = 1'b1;
        vld  = 1'b1;
        last = 1'b1;
        dat  = {~crc[0], ~crc[1], ~crc[2],
                ~crc[3], ~crc[4], fn[10:8]};
        if (acc) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign tx.SOF_TXREQ  = req;
  assign tx.SOF_TXVLD  = vld;
  assign tx.SOF_TXLAST = last;
  assign tx.SOF_TXDAT  = dat;
  assign SOF_BUSY      = (st != IDLE);

`ifdef SC_SCBC_SOFG_MISSCNT_EN
  logic [7:0] miss;
  logic [8:0] miss_sum;
  logic       unused_hi;

  assign miss_sum = {1'b0, miss}
                  + {8'h00, drop}
                  + {8'h00, tick_busy};
  assign unused_hi = ^FT_FMNUMBER[15:11];

  // Saturating dropped-SOF counter, cleared only by reset
  always_ff @(posedge ULPICLK or negedge ULPIRSTB) begin
    if (!ULPIRSTB) miss <= '0;
    else           miss <= miss_sum[8] ? 8'hFF : miss_sum[7:0];
  end

  assign SOF_MISSED = miss;
`else
  logic unused_drop;

  assign unused_drop = drop | tick_busy | (^FT_FMNUMBER[15:11]);
  assign SOF_MISSED  = 8'h00;
`endif

endmodule

// File: tb/tb_sc_scbc_sofg.sv
// Scoreboard bench for sc_scbc_sofg: expected bytes queued per tick,
// popped as the DUT hands bytes over.
module tb_sc_scbc_sofg;

  localparam int TMO = 64;

  logic        ULPICLK = 1'b0;
  logic        ULPIRSTB;
  logic        UPS_OPERATIONAL;
  logic        FT_1MS;
  logic [15:0] FT_FMNUMBER;
  logic        SOF_BUSY;
  logic [7:0]  SOF_MISSED;

  sc_scbc_sofg_if bus ();

  sc_scbc_sofg #(
    .SOF_PID     (8'hA5),
    .GNT_TIMEOUT (TMO)
  ) dut (
    .ULPICLK         (ULPICLK),
    .ULPIRSTB        (ULPIRSTB),
    .UPS_OPERATIONAL (UPS_OPERATIONAL),
    .FT_1MS          (FT_1MS),
    .FT_FMNUMBER     (FT_FMNUMBER),
    .tx              (bus),
    .SOF_BUSY        (SOF_BUSY),
    .SOF_MISSED      (SOF_MISSED)
  );

  always #5 ULPICLK = ~ULPICLK;

  int         errs = 0;
  int         checks = 0;
  int         exp_miss = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_exp;
  logic       stall_q = 1'b0;
  logic [7:0] stall_dat = 8'h00;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] miss_exp();
`ifdef SC_SCBC_SOFG_MISSCNT_EN
    return (exp_miss > 255) ? 8'hFF : 8'(exp_miss);
`else
    return 8'h00;
`endif
  endfunction

  function automatic logic [7:0] crc_byte(input logic [10:0] f);
    logic [4:0] c;
    logic       b;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      b = c[4] ^ f[i];
      c = {c[3:0], 1'b0};
      if (b) c = c ^ 5'b00101;
    end
    return {~c[0], ~c[1], ~c[2], ~c[3], ~c[4], f[10:8]};
  endfunction

  task automatic push_bytes(input logic [7:0] b0,
                            input logic [7:0] b1,
                            input logic [7:0] b2);
    sb.push_back({2'b10, b0});
    sb.push_back({2'b10, b1});
    sb.push_back({2'b11, b2});
  endtask

  task automatic push_token(input logic [15:0] f);
    push_bytes(8'hA5, f[7:0], crc_byte(f[10:0]));
  endtask

  task automatic pulse(input logic [15:0] f);
    @(posedge ULPICLK); #1;
    FT_1MS = 1'b1;
    FT_FMNUMBER = f;
    @(posedge ULPICLK); #1;
    FT_1MS = 1'b0;
  endtask

  task automatic step();
    @(posedge ULPICLK); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((SOF_BUSY || sb.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_busy"}, 32'(SOF_BUSY), 0);
    chk({tag, "_sb"}, sb.size(), 0);
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!bus.SOF_TXVLD && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, 32'(bus.SOF_TXVLD), 1);
  endtask

  // Byte monitor: handshake sampled mid-cycle, stalled bytes must hold
  always @(negedge ULPICLK) begin
    if (!ULPIRSTB) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q)
        chk("stall_hold", {23'd0, bus.SOF_TXVLD, bus.SOF_TXDAT},
            {23'd0, 1'b1, stall_dat});
      if (bus.SOF_TXVLD && bus.SOF_TXRDY) begin
        mon_exp = (sb.size() != 0) ? sb.pop_front() : 10'h000;
        chk("tx_byte", {22'd0, 1'b1, bus.SOF_TXLAST, bus.SOF_TXDAT},
            {22'd0, mon_exp});
      end
      stall_q   <= bus.SOF_TXVLD && !bus.SOF_TXRDY;
      stall_dat <= bus.SOF_TXDAT;
    end
  end

  initial begin
    logic [4:0] e_busy;
    logic [4:0] e_vld;
    logic [4:0] e_last;
    int         n;

    ULPIRSTB = 1'b0;
    UPS_OPERATIONAL = 1'b1;
    FT_1MS = 1'b0;
    FT_FMNUMBER = 16'h0000;
    bus.SOF_TXGNT = 1'b1;
    bus.SOF_TXRDY = 1'b1;
    #12;
    chk("rst_req", 32'(bus.SOF_TXREQ), 0);
    chk("rst_vld", 32'(bus.SOF_TXVLD), 0);
    chk("rst_last", 32'(bus.SOF_TXLAST), 0);
    chk("rst_dat", 32'(bus.SOF_TXDAT), 0);
    chk("rst_busy", 32'(SOF_BUSY), 0);
    chk("rst_miss", 32'(SOF_MISSED), 0);
    step();
    ULPIRSTB = 1'b1;
    repeat (2) step();

    // Frame 0 with per-cycle latency profile
    e_busy = 5'b01111;
    e_vld  = 5'b01110;
    e_last = 5'b01000;
    push_bytes(8'hA5, 8'h00, 8'h10);
    pulse(16'h0000);
    for (int k = 0; k < 5; k++) begin
      chk("f0_busy", 32'(SOF_BUSY), 32'(e_busy[k]));
      chk("f0_req", 32'(bus.SOF_TXREQ), 32'(e_busy[k]));
      chk("f0_vld", 32'(bus.SOF_TXVLD), 32'(e_vld[k]));
      chk("f0_last", 32'(bus.SOF_TXLAST), 32'(e_last[k]));
      if (k < 4) step();
    end
    wait_idle("f0");

    // Frame 0x7FF, upper bits of the frame number ignored
    push_bytes(8'hA5, 8'hFF, 8'h47);
    pulse(16'hF7FF);
    wait_idle("f7ff");

    // Backpressure with a second tick dropped while stalled
    bus.SOF_TXRDY = 1'b0;
    push_token(16'h0155);
    pulse(16'h0155);
    for (int b = 0; b < 3; b++) begin
      wait_vld("bp");
      if (b == 0) begin
        pulse(16'h0156);
        exp_miss++;
      end
      repeat (3) step();
      bus.SOF_TXRDY = 1'b1;
      step();
      bus.SOF_TXRDY = 1'b0;
    end
    bus.SOF_TXRDY = 1'b1;
    wait_idle("bp");
    chk("bp_miss", 32'(SOF_MISSED), 32'(miss_exp()));

    // Grant timeout
    bus.SOF_TXGNT = 1'b0;
    pulse(16'h0200);
    n = 0;
    while (bus.SOF_TXREQ && n < 300) begin
      n++;
      step();
    end
    exp_miss++;
    chk("tmo_len", n, TMO);
    chk("tmo_busy", 32'(SOF_BUSY), 0);
    chk("tmo_miss", 32'(SOF_MISSED), 32'(miss_exp()));
    bus.SOF_TXGNT = 1'b1;
    push_token(16'h0123);
    pulse(16'h0123);
    wait_idle("tmo_next");

    // Link loss while requesting aborts the token
    bus.SOF_TXGNT = 1'b0;
    pulse(16'h0321);
    chk("ups_req", 32'(bus.SOF_TXREQ), 1);
    UPS_OPERATIONAL = 1'b0;
    step();
    exp_miss++;
    chk("ups_req_busy", 32'(SOF_BUSY), 0);
    chk("ups_req_miss", 32'(SOF_MISSED), 32'(miss_exp()));
    UPS_OPERATIONAL = 1'b1;
    bus.SOF_TXGNT = 1'b1;

    // Link loss in FNL does not truncate
    push_token(16'h04AB);
    pulse(16'h04AB);
    step();
    step();
    UPS_OPERATIONAL = 1'b0;
    wait_idle("ups_fnl");
    chk("ups_fnl_miss", 32'(SOF_MISSED), 32'(miss_exp()));
    UPS_OPERATIONAL = 1'b1;

    // Ticks with the link down are ignored
    UPS_OPERATIONAL = 1'b0;
    pulse(16'h0011);
    step();
    chk("ups0_busy", 32'(SOF_BUSY), 0);
    chk("ups0_miss", 32'(SOF_MISSED), 32'(miss_exp()));
    UPS_OPERATIONAL = 1'b1;

    // Saturation of the drop counter
    bus.SOF_TXGNT = 1'b0;
    for (int i = 0; i < 260; i++) begin
      pulse(16'(i));
      UPS_OPERATIONAL = 1'b0;
      step();
      UPS_OPERATIONAL = 1'b1;
      exp_miss++;
    end
    chk("sat_miss", 32'(SOF_MISSED), 32'(miss_exp()));
    bus.SOF_TXGNT = 1'b1;

    // Reset in FNL clears everything at once
    push_token(16'h0777);
    pulse(16'h0777);
    step();
    step();
    chk("rmid_fnl", 32'(bus.SOF_TXDAT), 32'h77);
    ULPIRSTB = 1'b0;
    #1;
    chk("rmid_req", 32'(bus.SOF_TXREQ), 0);
    chk("rmid_vld", 32'(bus.SOF_TXVLD), 0);
    chk("rmid_last", 32'(bus.SOF_TXLAST), 0);
    chk("rmid_dat", 32'(bus.SOF_TXDAT), 0);
    chk("rmid_busy", 32'(SOF_BUSY), 0);
    chk("rmid_miss", 32'(SOF_MISSED), 0);
    sb.delete();
    exp_miss = 0;
    step();
    ULPIRSTB = 1'b1;
    step();
    push_token(16'h0642);
    pulse(16'h0642);
    wait_idle("post_rst");
    chk("post_rst_miss", 32'(SOF_MISSED), 32'(miss_exp()));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sc_scbc_sofg.md
Name: sc_scbc_sofg

Overview:
- Start-of-Frame token generator. Sits directly downstream of the frame timing controller.
- Consumes the 1 ms frame tick and the frame number.
- Builds the 3-byte USB SOF token: PID, 11-bit frame number, CRC5.
- Presents the token byte-wise to the ULPI transmit arbiter through a request/grant plus valid/ready handshake.

Parameters:
- SOF_PID, 8'hA5: PID byte sent first; the nibble/complement pattern is the USB SOF PID.
- GNT_TIMEOUT, 64: maximum ULPICLK cycles in REQ waiting for SOF_TXGNT before the SOF is dropped (range 1..255).

Ports:
- ULPICLK  in  1  ULPI 60 MHz clock.
- ULPIRSTB  in  1  asynchronous active-low reset.
- UPS_OPERATIONAL  in  1  USB port operational; SOFs are generated only while high.
- FT_1MS  in  1  one-cycle frame tick.
- FT_FMNUMBER  in  16  frame number; bits [10:0] are used.
- SOF_TXREQ  out  1  request for the ULPI transmit path.
- SOF_TXGNT  in  1  grant from the transmit arbiter.
- SOF_TXDAT  out  8  token byte.
- SOF_TXVLD  out  1  SOF_TXDAT valid.
- SOF_TXRDY  in  1  consumer accepts byte.
- SOF_TXLAST  out  1  current byte is the last of the token.
- SOF_BUSY  out  1  FSM not IDLE.
- SOF_MISSED  out  8  saturating count of dropped SOFs.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- States: IDLE, REQ, PID, FNL, FNH, and back to IDLE.
- IDLE:
  - FT_1MS=1 and UPS_OPERATIONAL=1 → latch FN=FT_FMNUMBER[10:0] and compute the CRC5.
  - Go to REQ next cycle and assert SOF_TXREQ.
- REQ:
  - SOF_TXREQ=1. SOF_TXGNT=1 → PID.
  - Timeout counter reaches GNT_TIMEOUT without a grant → IDLE and SOF_MISSED+1.
  - UPS_OPERATIONAL falls → IDLE and SOF_MISSED+1.
- PID / FNL / FNH:
  - SOF_TXREQ stays 1. SOF_TXVLD=1.
  - SOF_TXDAT is SOF_PID, then FN[7:0], then {~crc[0],~crc[1],~crc[2],~crc[3],~crc[4],FN[10:8]} (bit7..bit0).
  - Advance only on SOF_TXVLD&&SOF_TXRDY. Data is held stable while SOF_TXRDY=0.
  - SOF_TXLAST=1 in FNH only.
  - Accepting the FNH byte → IDLE. VLD, REQ and LAST drop in the following cycle.
- Once granted, the token always completes. UPS_OPERATIONAL falling in PID/FNL/FNH does not truncate it.
- SOF_TXGNT deasserting mid-token is a protocol violation; the FSM ignores it.
- CRC5:
  - Polynomial x^5+x^2+1, init 5'b11111.
  - Data processed FN[0] first. Serial step: fb=crc[4]^d; crc={crc[3:0],1'b0}^(fb?5'b00101:0).
  - Computed combinationally from the latched FN: 11 unrolled steps, no extra latency.
- FT_1MS while SOF_BUSY=1: tick dropped, SOF_MISSED+1, current token unaffected.
- FT_1MS with UPS_OPERATIONAL=0: ignored, no count.
- SOF_MISSED saturates at 8'hFF. It is cleared only by reset.
- Latency: FT_1MS at cycle N → SOF_TXREQ at N+1. With GNT and RDY held high: PID at N+2, FNL at N+3, FNH at N+4, SOF_BUSY=0 at N+5.
- Reset asserted mid-token: immediate return to IDLE, all outputs 0, no partial completion.

Optional Feature:
- Macro: SC_SCBC_SOFG_MISSCNT_EN.
- Defined: SOF_MISSED counter implemented as above.
- Undefined: counter removed; SOF_MISSED tied to 8'h00. All drop conditions still drop the SOF identically.

Test Plan:
- Frame 0: UPS_OPERATIONAL=1, GNT=RDY=1, FT_FMNUMBER=16'h0000, FT_1MS pulse → bytes A5, 00, 10; LAST on the third byte; SOF_BUSY low 5 cycles after the tick.
- Frame 0x7FF: FT_FMNUMBER=16'hF7FF, FT_1MS pulse → bytes A5, FF, 47 (upper bits ignored).
- Backpressure: SOF_TXRDY low 3 cycles on each byte → SOF_TXDAT/VLD stable while stalled; same byte sequence; no byte duplicated or skipped.
- Grant timeout: SOF_TXGNT held 0 → REQ held exactly GNT_TIMEOUT cycles, then drop; SOF_MISSED=1. Next tick with grant sends normally.
- Overlap and link loss:
  - Second FT_1MS while RDY=0 holds the token → SOF_MISSED+1, first token completes.
  - UPS_OPERATIONAL=0 in REQ → abort, SOF_MISSED+1.
  - UPS_OPERATIONAL=0 during FNL → token completes.
- Reset mid-token in FNL → all outputs 0 immediately. After reset release, a tick sends a full token with SOF_MISSED=0.
